// File: rtl/bs_lut_ld_unpack.sv
// rtl/bs_lut_ld_unpack.sv - stream loader for the bit-serial LUT core's ping-pong act/wgt buffers
//
// Unpacks each BUS_DW-bit stream beat into LANES elements of ELEM_DW bits and
// writes them into NUM_BUF per-row/per-column buffers, one lane group per beat.
// Two banks are tracked; a bank stays full (owned by execute) until released.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cfg_start, cfg_len           start pulse and number of addresses to load
//   busy, done, err              status: loading, completion pulse, sticky error
//   s_axis_t*                    input stream (tdata/tvalid/tlast/tready)
//   bank_full                    per-bank "loaded, owned by execute"
//   ex_release, ex_bank          execute side frees a bank
//   buf_wr_en/addr/sel/data      buffer write port (one enable/element per buffer)
module bs_lut_ld_unpack #(
    parameter int NUM_BUF = 40,
    parameter int ELEM_DW = 4,
    parameter int BUS_DW  = 64,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_start,
    input  logic [ADDR_W:0]             cfg_len,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    input  logic [BUS_DW-1:0]           s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [1:0]                  bank_full,
    input  logic                        ex_release,
    input  logic                        ex_bank,
    output logic [NUM_BUF-1:0]          buf_wr_en,
    output logic [ADDR_W-1:0]           buf_wr_addr,
    output logic                        buf_wr_sel,
    output logic [NUM_BUF*ELEM_DW-1:0]  buf_wr_data
);

    localparam int LANES  = BUS_DW / ELEM_DW;
    localparam int GROUPS = (NUM_BUF + LANES - 1) / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       r_ld_bank;
    logic [1:0]                 r_bank_full;
    logic                       r_err;
    logic                       r_done;
    logic [ADDR_W:0]            r_len;
    logic [ADDR_W-1:0]          r_addr;
    logic [GRP_W-1:0]           r_grp;
    logic [NUM_BUF-1:0]         r_wr_en;
    logic [ADDR_W-1:0]          r_wr_addr;
    logic                       r_wr_sel;
    logic [NUM_BUF*ELEM_DW-1:0] r_wr_data;

    logic w_idle_start;
    logic w_cfg_zero;
    logic w_cfg_bad;
    logic w_cfg_ok;
    logic w_xfer;
    logic w_at_last;
    logic w_final;

    assign w_idle_start = cfg_start && (r_state == S_IDLE);
    assign w_cfg_zero   = w_idle_start && (cfg_len == '0);
    assign w_cfg_bad    = w_idle_start && (cfg_len > DEPTH_L);
    assign w_cfg_ok     = w_idle_start && !w_cfg_zero && !w_cfg_bad;

    assign w_xfer    = (r_state == S_LOAD) && s_axis_tvalid;
    // Counter position of the final beat; tlast is only checked against it.
    assign w_at_last = ({1'b0, r_addr} == (r_len - (ADDR_W+1)'(1))) && (r_grp == LAST_GRP);
    assign w_final   = w_xfer && w_at_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_cfg_ok) w_state_nxt = S_WAIT;
            S_WAIT: if (!r_bank_full[r_ld_bank]) w_state_nxt = S_LOAD;
            S_LOAD: if (w_final) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= '0;
            r_addr      <= '0;
            r_grp       <= '0;
            r_wr_addr   <= '0;
            r_wr_sel    <= 1'b0;
        end else begin
            r_done <= w_cfg_zero || w_final;

            if (w_cfg_bad || (w_xfer && (s_axis_tlast != w_at_last)))
                r_err <= 1'b1;

            if (w_cfg_ok) begin
                r_len  <= cfg_len;
                r_addr <= '0;
                r_grp  <= '0;
            end

            if (w_xfer) begin
                r_wr_addr <= r_addr;
                r_wr_sel  <= r_ld_bank;
                if (r_grp == LAST_GRP) begin
                    r_grp  <= '0;
                    r_addr <= r_addr + ADDR_W'(1);
                end else begin
                    r_grp <= r_grp + GRP_W'(1);
                end
            end

            // Release first so a completion on the same bank overrides it.
            if (ex_release)
                r_bank_full[ex_bank] <= 1'b0;
            if (w_final) begin
                r_bank_full[r_ld_bank] <= 1'b1;
                r_ld_bank              <= ~r_ld_bank;
            end
        end
    end

    // Buffer b belongs to group b/LANES and takes lane b%LANES; lanes past
    // NUM_BUF in the last group have no buffer and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en   <= '0;
            r_wr_data <= '0;
        end else begin
            for (int b = 0; b < NUM_BUF; b++) begin
                if (w_xfer && (r_grp == GRP_W'(b / LANES))) begin
                    r_wr_en[b] <= 1'b1;
                    r_wr_data[b*ELEM_DW +: ELEM_DW] <=
                        s_axis_tdata[(b % LANES)*ELEM_DW +: ELEM_DW];
                end else begin
                    r_wr_en[b] <= 1'b0;
                end
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign s_axis_tready = (r_state == S_LOAD);
    assign done          = r_done;
    assign err           = r_err;
    assign bank_full     = r_bank_full;
    assign buf_wr_en     = r_wr_en;
    assign buf_wr_addr   = r_wr_addr;
    assign buf_wr_sel    = r_wr_sel;
    assign buf_wr_data   = r_wr_data;

endmodule

// File: tb/tb_bs_lut_ld_unpack.sv
// tb/tb_bs_lut_ld_unpack.sv - self-checking bench for bs_lut_ld_unpack
module tb_bs_lut_ld_unpack;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default instance: NUM_BUF=40, ELEM_DW=4 -> LANES=16, GROUPS=3
    logic         cfg_start;
    logic [9:0]   cfg_len;
    logic         busy, done, err;
    logic [63:0]  tdata;
    logic         tvalid, tlast, tready;
    logic [1:0]   bank_full;
    logic         ex_release, ex_bank;
    logic [39:0]  wr_en;
    logic [8:0]   wr_addr;
    logic         wr_sel;
    logic [159:0] wr_data;

    // second instance: NUM_BUF=32, ELEM_DW=8 -> LANES=8, GROUPS=4
    logic         p2_cfg_start;
    logic [9:0]   p2_cfg_len;
    logic         p2_busy, p2_done, p2_err;
    logic [63:0]  p2_tdata;
    logic         p2_tvalid, p2_tlast, p2_tready;
    logic [1:0]   p2_bank_full;
    logic         p2_ex_release, p2_ex_bank;
    logic [31:0]  p2_wr_en;
    logic [8:0]   p2_wr_addr;
    logic         p2_wr_sel;
    logic [255:0] p2_wr_data;

    bs_lut_ld_unpack dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .busy(busy), .done(done), .err(err),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready), .bank_full(bank_full),
        .ex_release(ex_release), .ex_bank(ex_bank),
        .buf_wr_en(wr_en), .buf_wr_addr(wr_addr), .buf_wr_sel(wr_sel),
        .buf_wr_data(wr_data)
    );

    bs_lut_ld_unpack #(.NUM_BUF(32), .ELEM_DW(8)) dut_p2 (
        .clk(clk), .rst_n(rst_n), .cfg_start(p2_cfg_start), .cfg_len(p2_cfg_len),
        .busy(p2_busy), .done(p2_done), .err(p2_err),
        .s_axis_tdata(p2_tdata), .s_axis_tvalid(p2_tvalid), .s_axis_tlast(p2_tlast),
        .s_axis_tready(p2_tready), .bank_full(p2_bank_full),
        .ex_release(p2_ex_release), .ex_bank(p2_ex_bank),
        .buf_wr_en(p2_wr_en), .buf_wr_addr(p2_wr_addr), .buf_wr_sel(p2_wr_sel),
        .buf_wr_data(p2_wr_data)
    );

    int errors = 0;
    int checks = 0;
    int gap_bad;

    typedef struct {
        logic [39:0]  en;
        logic [8:0]   addr;
        logic         sel;
        logic [159:0] data;
    } wr_t;

    typedef struct {
        logic [63:0] data;
        logic [39:0] en;
        logic [8:0]  addr;
        logic [3:0]  b0;
        logic        done;
    } vec_t;

    wr_t         wq[$];
    logic [63:0] sent[$];
    vec_t        tbl[6];
    logic [39:0] exp_en_tab[3];
    logic [63:0] p2_tbl[4];
    logic [31:0] p2_en[4];
    logic [7:0]  p2_b0[4];

    always @(negedge clk)
        if (wr_en != 40'd0) wq.push_back('{wr_en, wr_addr, wr_sel, wr_data});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [9:0] len);
        cfg_len   = len;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic last);
        int n;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        n = 0;
        while (!tready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_wait", tready, 1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_load(input int n, input bit gap, input int tlast_at);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            if (gap && ($urandom_range(0, 1) == 1)) begin
                repeat ($urandom_range(1, 2)) begin
                    tvalid = 1'b0;
                    tick();
                    if (wr_en != 40'd0) gap_bad++;
                end
            end
            d = {$urandom, $urandom};
            sent.push_back(d);
            beat(d, (i + 1) == tlast_at);
        end
    endtask

    task automatic check_records(input int n, input logic sel);
        wr_t         r;
        logic [63:0] d;
        logic        ok;
        int          g;
        chk("wr_count", wq.size(), n);
        for (int j = 0; j < n && j < wq.size(); j++) begin
            r = wq[j];
            d = sent[j];
            g = j % 3;
            chk("wr_en", r.en, exp_en_tab[g]);
            chk("wr_addr", r.addr, j / 3);
            chk("wr_sel", r.sel, sel);
            ok = 1'b1;
            for (int b = 0; b < 40; b++)
                if (b / 16 == g && r.data[b*4 +: 4] !== d[(b - g*16)*4 +: 4]) ok = 1'b0;
            chk("wr_data", ok, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   g, n0, n;

        exp_en_tab[0] = 40'h00_0000_FFFF;
        exp_en_tab[1] = 40'h00_FFFF_0000;
        exp_en_tab[2] = 40'hFF_0000_0000;
        tbl[0] = '{64'hFEDC_BA98_7654_3210, 40'h00_0000_FFFF, 9'd0, 4'h0, 1'b0};
        tbl[1] = '{64'h0123_4567_89AB_CDEF, 40'h00_FFFF_0000, 9'd0, 4'hF, 1'b0};
        tbl[2] = '{64'h1111_2222_3333_4A5B, 40'hFF_0000_0000, 9'd0, 4'hB, 1'b0};
        tbl[3] = '{64'h5555_6666_7777_8889, 40'h00_0000_FFFF, 9'd1, 4'h9, 1'b0};
        tbl[4] = '{64'hAAAA_BBBB_CCCC_DDDE, 40'h00_FFFF_0000, 9'd1, 4'hE, 1'b0};
        tbl[5] = '{64'h9999_0000_1234_567C, 40'hFF_0000_0000, 9'd1, 4'hC, 1'b1};
        p2_tbl[0] = 64'h0706_0504_0302_0100;
        p2_tbl[1] = 64'h1716_1514_1312_1110;
        p2_tbl[2] = 64'h2726_2524_2322_2120;
        p2_tbl[3] = 64'h3736_3534_3332_3130;
        p2_en[0] = 32'h0000_00FF; p2_en[1] = 32'h0000_FF00;
        p2_en[2] = 32'h00FF_0000; p2_en[3] = 32'hFF00_0000;
        p2_b0[0] = 8'h00; p2_b0[1] = 8'h10; p2_b0[2] = 8'h20; p2_b0[3] = 8'h30;

        rst_n = 1'b0;
        cfg_start = 0; cfg_len = 0; tdata = 0; tvalid = 0; tlast = 0;
        ex_release = 0; ex_bank = 0;
        p2_cfg_start = 0; p2_cfg_len = 0; p2_tdata = 0; p2_tvalid = 0; p2_tlast = 0;
        p2_ex_release = 0; p2_ex_bank = 0;
        gap_bad = 0;
        repeat (3) tick();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tready", tready, 0);
        chk("rst_bank_full", bank_full, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data[63:0], 0);
        chk("rst_p2_tready", p2_tready, 0);
        rst_n = 1'b1;
        tick();

        // basic cfg_len=2 load, table-driven
        start(10'd2);
        chk("a_busy", busy, 1);
        chk("a_wait_tready", tready, 0);
        for (int i = 0; i < 6; i++) begin
            beat(tbl[i].data, i == 5);
            g = i % 3;
            chk("a_wr_en", wr_en, tbl[i].en);
            chk("a_wr_addr", wr_addr, tbl[i].addr);
            chk("a_wr_sel", wr_sel, 0);
            chk("a_done", done, tbl[i].done);
            chk("a_low_buf", wr_data[g*64 +: 4], tbl[i].b0);
            ok = 1'b1;
            for (int b = 0; b < 40; b++)
                if (b / 16 == g && wr_data[b*4 +: 4] !== tbl[i].data[(b - g*16)*4 +: 4]) ok = 1'b0;
            chk("a_wr_data", ok, 1);
        end
        chk("a_bank_full", bank_full, 2'b01);
        chk("a_busy_end", busy, 0);
        chk("a_err", err, 0);
        tick();
        chk("a_done_pulse", done, 0);
        chk("a_wr_en_idle", wr_en, 0);

        // cfg_len=4 into bank 1 with random valid gaps
        tick();
        wq.delete(); sent.delete(); gap_bad = 0;
        start(10'd4);
        send_load(12, 1'b1, 12);
        tick(); tick();
        check_records(12, 1'b1);
        chk("b_gap_writes", gap_bad, 0);
        chk("b_bank_full", bank_full, 2'b11);
        chk("b_err", err, 0);

        // third load blocks until bank 0 released; tlast early on beat 3
        start(10'd2);
        repeat (5) tick();
        chk("c_busy", busy, 1);
        chk("c_tready", tready, 0);
        chk("c_bank_full", bank_full, 2'b11);
        ex_bank = 1'b0; ex_release = 1'b1;
        tick();
        ex_release = 1'b0;
        chk("c_released", bank_full, 2'b10);
        chk("c_still_wait", tready, 0);
        tick();
        chk("c_load", tready, 1);
        wq.delete(); sent.delete();
        send_load(6, 1'b0, 3);
        chk("c_done", done, 1);
        tick(); tick();
        check_records(6, 1'b0);
        chk("c_err", err, 1);
        chk("c_bank_full_end", bank_full, 2'b11);

        // zero-length start
        n0 = wq.size();
        start(10'd0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        tick();
        chk("z_done_pulse", done, 0);
        chk("z_no_writes", wq.size(), n0);
        chk("z_bank_full", bank_full, 2'b11);

        // reset mid-load
        ex_release = 1'b1; ex_bank = 1'b0;
        tick();
        ex_bank = 1'b1;
        tick();
        ex_release = 1'b0;
        chk("r_released", bank_full, 2'b00);
        start(10'd2);
        send_load(2, 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("r_busy", busy, 0);
        chk("r_tready", tready, 0);
        chk("r_bank_full", bank_full, 2'b00);
        chk("r_err", err, 0);
        chk("r_wr_en", wr_en, 0);
        n0 = wq.size();
        tvalid = 1'b1;
        repeat (5) tick();
        tvalid = 1'b0;
        tick();
        chk("r_no_writes", wq.size(), n0);

        // oversize length sets err and is ignored; next load goes to bank 0
        start(10'd513);
        chk("o_err", err, 1);
        chk("o_busy", busy, 0);
        tick();
        chk("o_no_done", done, 0);
        wq.delete(); sent.delete();
        start(10'd1);
        send_load(3, 1'b0, 3);
        tick(); tick();
        check_records(3, 1'b0);
        chk("o_bank_full", bank_full, 2'b01);

        // 32 buffers of bytes, cfg_len=1
        p2_cfg_len = 10'd1;
        p2_cfg_start = 1'b1;
        tick();
        p2_cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p2_tdata = p2_tbl[i];
            p2_tlast = (i == 3);
            p2_tvalid = 1'b1;
            n = 0;
            while (!p2_tready && n < 100) begin
                tick();
                n++;
            end
            chk("p2_ready_wait", p2_tready, 1);
            tick();
            p2_tvalid = 1'b0;
            p2_tlast = 1'b0;
            chk("p2_wr_en", p2_wr_en, p2_en[i]);
            chk("p2_wr_addr", p2_wr_addr, 0);
            chk("p2_done", p2_done, i == 3);
            chk("p2_low_buf", p2_wr_data[i*64 +: 8], p2_b0[i]);
            ok = 1'b1;
            for (int b = 0; b < 32; b++)
                if (b / 8 == i && p2_wr_data[b*8 +: 8] !== p2_tbl[i][(b % 8)*8 +: 8]) ok = 1'b0;
            chk("p2_wr_data", ok, 1);
        end
        chk("p2_bank_full", p2_bank_full, 2'b01);
        chk("p2_err", p2_err, 0);
        tick();
        chk("p2_idle", p2_wr_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bs_lut_ld_unpack.md
Name: bs_lut_ld_unpack

Overview:
- Parametrised loader for the bit-serial LUT core's ping-pong act/wgt buffers.
- Accepts a 64-bit AXI-stream and unpacks each beat into NUM_BUF per-row/per-column buffer write lanes of ELEM_DW bits.
- Handles a partial last lane group generically, with no hand-wired tail lanes.
- Tracks fill state of two banks, applies backpressure when the target bank is still owned by the execute side, and hands off banks through a full/release handshake.

Parameters:
NUM_BUF, 40, number of target buffers (PE rows or columns); >=1
ELEM_DW, 4, element width per buffer (4 = wgt idx, 8 = act); must divide BUS_DW
BUS_DW, 64, stream data width
DEPTH, 512, addresses per bank per buffer
ADDR_W, 9, buffer address width; 2^ADDR_W >= DEPTH
Derived: LANES = BUS_DW/ELEM_DW; GROUPS = ceil(NUM_BUF/LANES)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_start  in  1  pulse; begin loading cfg_len addresses
cfg_len  in  ADDR_W+1  addresses to load, 0..DEPTH
busy  out  1  load in progress
done  out  1  one-cycle pulse on load completion
err  out  1  sticky; tlast mismatch or cfg_len > DEPTH
s_axis_tdata  in  BUS_DW  packed elements, lane k = bits [ELEM_DW*(k+1)-1 : ELEM_DW*k]
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of load
s_axis_tready  out  1  beat accept
bank_full  out  2  per-bank "loaded, owned by execute"
ex_release  in  1  pulse; execute side frees bank ex_bank
ex_bank  in  1  bank being released
buf_wr_en  out  NUM_BUF  per-buffer write enable
buf_wr_addr  out  ADDR_W  common write address
buf_wr_sel  out  1  bank being written
buf_wr_data  out  NUM_BUF*ELEM_DW  per-buffer write data

Behaviour:
- Reset (synchronous, active-low; clock clk):
  - state IDLE; ld_bank=0; bank_full=2'b00; err=0.
  - busy=0, done=0, tready=0; all buf_wr_* = 0.
  - Reset mid-load abandons the load; partial bank contents are don't-care and the bank is not marked full.
- FSM IDLE -> WAIT -> LOAD -> IDLE.
- IDLE:
  - cfg_start with cfg_len==0 -> done pulse next cycle, bank and flags unchanged, stay IDLE.
  - cfg_len>DEPTH -> set err, ignore the start.
  - Otherwise latch len, clear addr/grp counters, go WAIT.
  - cfg_start while not IDLE is ignored.
- WAIT: tready=0. When bank_full[ld_bank]==0, go LOAD.
- LOAD:
  - tready=1. A beat transfers on tvalid&&tready.
  - Each transfer registers one cycle later: buf_wr_en[g*LANES+k]=1 for every lane k with g*LANES+k<NUM_BUF, where g is the current group; buf_wr_data for those buffers = lane k; buf_wr_addr=addr; buf_wr_sel=ld_bank. Lanes beyond NUM_BUF are discarded.
  - Order: grp 0..GROUPS-1 at addr 0, then addr 1, ... Total beats = len*GROUPS.
  - grp wraps to 0 and addr increments at GROUPS-1.
  - On the final beat (addr==len-1, grp==GROUPS-1): next cycle bank_full[ld_bank]<=1, ld_bank toggles, done pulses, state IDLE. done coincides with the final write cycle.
- tlast: must be 1 exactly on the final beat. Any mismatch sets err. Data is still written, and the count, not tlast, terminates the load.
- Non-transfer cycles: buf_wr_en=0; addr/data hold.
- ex_release clears bank_full[ex_bank] next cycle.
  - Release of the bank completing on the same cycle: completion wins (flag set).
  - Release of the other bank on the same cycle: both updates apply.
- WAIT->LOAD happens in the cycle after the release is visible (flag low).
- busy=1 in WAIT and LOAD.

Test Plan:
- Defaults (LANES=16, GROUPS=3), cfg_len=2, 6 beats tvalid=1, tlast on beat 6 -> 6 write cycles; beats 1,4 enable bufs 0-15, beats 2,5 bufs 16-31, beats 3,6 bufs 32-39 only with buf 32 = lanes [3:0]; addr 0,0,0,1,1,1; sel=0; done with 6th write; bank_full=01; ld_bank=1.
- Two loads then a third start with no release -> third stays in WAIT, tready=0, bank_full=11. Pulse ex_release with ex_bank=0 -> bank_full=10, load proceeds into bank 0.
- Random tvalid gaps (~50%) on a cfg_len=4 load -> exactly 12 write cycles, addresses and data unchanged vs gapless run, no writes in gap cycles.
- tlast asserted on beat 3 of 6 -> err=1 sticky, load still completes after 6 beats. cfg_len=0 -> done next cycle, no writes, bank_full unchanged.
- rst_n low for one cycle mid-load (after beat 2) -> next cycle busy=0, tready=0, bank_full=00, ld_bank=0, no further writes.
- NUM_BUF=32, ELEM_DW=8 (LANES=8, GROUPS=4), cfg_len=1 -> 4 beats, bufs 0-7,8-15,16-23,24-31 written at addr 0, each with the matching byte lanes.
